// File: rtl/dac_out_pkg.sv
// Shared types and constants for the DAC output stage and related converters.
package dac_out_pkg;

    localparam int DIN_W  = 16;
    localparam int DAC_W  = 14;
    localparam int GAIN_W = 9;
    localparam int PROD_W = 23;

    localparam logic [GAIN_W-1:0] GAIN_FULL = 9'd256;
    localparam logic [GAIN_W-1:0] GAIN_ZERO = 9'd0;

    localparam logic [DAC_W-1:0] ZERO_CODE_OFFSET = 14'h2000;
    localparam logic [DAC_W-1:0] ZERO_CODE_TWOS   = 14'h0000;

    typedef enum logic [1:0] {
        ST_MUTED     = 2'd0,
        ST_RAMP_UP   = 2'd1,
        ST_RUN       = 2'd2,
        ST_RAMP_DOWN = 2'd3
    } dac_state_e;

    // Offset binary is two's complement with the sign bit flipped.
    function automatic logic [DAC_W-1:0] fmt_code(input logic [DAC_W-1:0] v,
                                                  input logic offset_bin);
        return {v[DAC_W-1] ^ offset_bin, v[DAC_W-2:0]};
    endfunction

    function automatic logic [DAC_W-1:0] zero_code(input logic offset_bin);
        return offset_bin ? ZERO_CODE_OFFSET : ZERO_CODE_TWOS;
    endfunction

endpackage

// File: rtl/sat16to14.sv
// Combinational saturator: 16-bit signed in, 14-bit signed out, with clip flag.
module sat16to14 (
    input  logic signed [15:0] din,
    output logic signed [13:0] dout,
    output logic               clip
);

    localparam logic signed [15:0] MAX14 = 16'sd8191;
    localparam logic signed [15:0] MIN14 = -16'sd8192;

    // Clamp to the 14-bit range and report when clamping happened.
    always_comb begin
        dout = din[13:0];
        clip = 1'b0;
        if (din > MAX14) begin
            dout = 14'sh1FFF;
            clip = 1'b1;
        end else if (din < MIN14) begin
            dout = 14'sh2000;
            clip = 1'b1;
        end
    end

endmodule

// File: rtl/dac_output_stage.sv
// DAC output stage: saturate, gain-ramp (mute/unmute), format and register
// samples for the DAC pins; tracks input clipping.
//
//   state        | meaning
//   -------------+-------------------------------------------------
//   ST_MUTED     | gain held at 0, output is the zero code
//   ST_RAMP_UP   | gain rises by RAMP_STEP per accepted sample
//   ST_RUN       | gain held at full scale (256)
//   ST_RAMP_DOWN | gain falls by RAMP_STEP per accepted sample
module dac_output_stage
    import dac_out_pkg::*;
#(
    parameter bit          OFFSET_BIN = 1'b1,
    parameter int unsigned RAMP_STEP  = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic signed [DIN_W-1:0] din,
    input  logic                    din_valid,
    input  logic                    mute,
    input  logic                    clip_clr,
    output logic [DAC_W-1:0]        dac_out,
    output logic                    dac_valid,
    output logic                    ramp_busy,
    output logic                    clip_flag,
    output logic [15:0]             clip_count
);

    localparam logic [GAIN_W:0] STEP_EXT = (GAIN_W + 1)'(RAMP_STEP);

    dac_state_e state_q, state_d;
    logic [GAIN_W-1:0] gain_q, gain_d;
    logic [GAIN_W:0]   gain_up;

    logic signed [DAC_W-1:0] s1_data_q, s1_data_d;
    logic [GAIN_W-1:0]       s1_gain_q, s1_gain_d;
    logic                    s1_valid_q, s1_valid_d;

    logic [DAC_W-1:0] dac_out_q, dac_out_d;
    logic             dac_valid_q, dac_valid_d;
    logic             ramp_busy_q, ramp_busy_d;
    logic             clip_flag_q, clip_flag_d;
    logic [15:0]      clip_count_q, clip_count_d;

    logic signed [DAC_W-1:0]  sat_dout;
    logic                     sat_clip;
    logic signed [PROD_W-1:0] data_ext, gain_ext, product;
    logic [DAC_W-1:0]         scaled;
    logic                     unused_prod;

    sat16to14 u_sat (
        .din  (din),
        .dout (sat_dout),
        .clip (sat_clip)
    );

    // Mute FSM and gain ramp; gain only moves on accepted samples.
    always_comb begin
        state_d = state_q;
        gain_d  = gain_q;
        gain_up = {1'b0, gain_q} + STEP_EXT;
        case (state_q)
            ST_MUTED: begin
                if (!mute) state_d = ST_RAMP_UP;
            end
            ST_RAMP_UP: begin
                if (mute) begin
                    state_d = ST_RAMP_DOWN;
                end else if (din_valid) begin
                    if (gain_up >= {1'b0, GAIN_FULL}) begin
                        gain_d  = GAIN_FULL;
                        state_d = ST_RUN;
                    end else begin
                        gain_d = gain_up[GAIN_W-1:0];
                    end
                end
            end
            ST_RUN: begin
                if (mute) state_d = ST_RAMP_DOWN;
            end
            ST_RAMP_DOWN: begin
                if (!mute) begin
                    state_d = ST_RAMP_UP;
                end else if (din_valid) begin
                    if ({1'b0, gain_q} <= STEP_EXT) begin
                        gain_d  = GAIN_ZERO;
                        state_d = ST_MUTED;
                    end else begin
                        gain_d = gain_q - STEP_EXT[GAIN_W-1:0];
                    end
                end
            end
            default: begin
                state_d = ST_MUTED;
                gain_d  = GAIN_ZERO;
            end
        endcase
        ramp_busy_d = (state_d == ST_RAMP_UP) || (state_d == ST_RAMP_DOWN);
    end

    // Stage 1 captures the saturated sample with the gain in force before this sample's update.
    always_comb begin
        s1_valid_d = din_valid;
        s1_data_d  = s1_data_q;
        s1_gain_d  = s1_gain_q;
        if (din_valid) begin
            s1_data_d = sat_dout;
            s1_gain_d = gain_q;
        end
    end

    // Stage 2: scale by gain/256 with floor rounding, format, and hold when idle.
    always_comb begin
        data_ext    = {{(PROD_W - DAC_W){s1_data_q[DAC_W-1]}}, s1_data_q};
        gain_ext    = {{(PROD_W - GAIN_W){1'b0}}, s1_gain_q};
        product     = data_ext * gain_ext;
        scaled      = product[DAC_W+7:8];
        unused_prod = ^{product[PROD_W-1], product[7:0]};
        dac_valid_d = s1_valid_q;
        dac_out_d   = s1_valid_q ? fmt_code(scaled, OFFSET_BIN) : dac_out_q;
    end

    // Sticky clip flag and saturating clip counter; a clear beats a coincident clip.
    always_comb begin
        clip_flag_d  = clip_flag_q;
        clip_count_d = clip_count_q;
        if (clip_clr) begin
            clip_flag_d  = 1'b0;
            clip_count_d = 16'h0000;
        end else if (din_valid && sat_clip) begin
            clip_flag_d = 1'b1;
            if (clip_count_q != 16'hFFFF) clip_count_d = clip_count_q + 16'h0001;
        end
    end

    // All state registers; reset drops any in-flight samples.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_MUTED;
            gain_q       <= GAIN_ZERO;
            s1_data_q    <= '0;
            s1_gain_q    <= GAIN_ZERO;
            s1_valid_q   <= 1'b0;
            dac_out_q    <= zero_code(OFFSET_BIN);
            dac_valid_q  <= 1'b0;
            ramp_busy_q  <= 1'b0;
            clip_flag_q  <= 1'b0;
            clip_count_q <= 16'h0000;
        end else begin
            state_q      <= state_d;
            gain_q       <= gain_d;
            s1_data_q    <= s1_data_d;
            s1_gain_q    <= s1_gain_d;
            s1_valid_q   <= s1_valid_d;
            dac_out_q    <= dac_out_d;
            dac_valid_q  <= dac_valid_d;
            ramp_busy_q  <= ramp_busy_d;
            clip_flag_q  <= clip_flag_d;
            clip_count_q <= clip_count_d;
        end
    end

    assign dac_out    = dac_out_q;
    assign dac_valid  = dac_valid_q;
    assign ramp_busy  = ramp_busy_q;
    assign clip_flag  = clip_flag_q;
    assign clip_count = clip_count_q;

endmodule

// File: tb/tb_dac_output_stage.sv
// Testbench for dac_output_stage (offset binary, RAMP_STEP = 64).
module tb_dac_output_stage;

    logic        clk;
    logic        rst;
    logic [15:0] din;
    logic        din_valid;
    logic        mute;
    logic        clip_clr;
    logic [13:0] dac_out;
    logic        dac_valid;
    logic        ramp_busy;
    logic        clip_flag;
    logic [15:0] clip_count;

    int n_vec;
    int n_err;

    typedef struct {
        logic [15:0] din;
        logic        vld;
        logic        mute;
        logic        clr;
        logic        ev;
        logic [13:0] eo;
        logic        eb;
        logic        ef;
        logic [15:0] ec;
    } vec_t;

    vec_t tbl [34];

    dac_output_stage #(
        .OFFSET_BIN (1'b1),
        .RAMP_STEP  (64)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .din        (din),
        .din_valid  (din_valid),
        .mute       (mute),
        .clip_clr   (clip_clr),
        .dac_out    (dac_out),
        .dac_valid  (dac_valid),
        .ramp_busy  (ramp_busy),
        .clip_flag  (clip_flag),
        .clip_count (clip_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mk(input int d, input bit v, input bit m, input bit c,
                                input bit ev, input int eo, input bit eb,
                                input bit ef, input int ec);
        vec_t r;
        r.din  = 16'(d);
        r.vld  = v;
        r.mute = m;
        r.clr  = c;
        r.ev   = ev;
        r.eo   = 14'(eo);
        r.eb   = eb;
        r.ef   = ef;
        r.ec   = 16'(ec);
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic ev, input logic [13:0] eo,
                           input logic eb, input logic ef, input logic [15:0] ec);
        n_vec++;
        chk({tag, ".dac_valid"},  32'(dac_valid),  32'(ev));
        chk({tag, ".dac_out"},    32'(dac_out),    32'(eo));
        chk({tag, ".ramp_busy"},  32'(ramp_busy),  32'(eb));
        chk({tag, ".clip_flag"},  32'(clip_flag),  32'(ef));
        chk({tag, ".clip_count"}, 32'(clip_count), 32'(ec));
    endtask

    task automatic step(input int d, input bit v, input bit m, input bit c);
        din       = 16'(d);
        din_valid = v;
        mute      = m;
        clip_clr  = c;
        @(posedge clk);
        #1;
    endtask

    initial begin
        int seen;
        n_vec = 0;
        n_err = 0;

        //            din    vld mute clr  ev  out     busy flag cnt
        tbl[0]  = mk(0,      0, 1, 0,  0, 'h2000, 0, 0, 0);
        tbl[1]  = mk(4096,   1, 1, 0,  0, 'h2000, 0, 0, 0);
        tbl[2]  = mk(0,      0, 0, 0,  1, 'h2000, 1, 0, 0);
        tbl[3]  = mk(4096,   1, 0, 0,  0, 'h2000, 1, 0, 0);
        tbl[4]  = mk(4096,   1, 0, 0,  1, 'h2000, 1, 0, 0);
        tbl[5]  = mk(4096,   1, 0, 0,  1, 'h2400, 1, 0, 0);
        tbl[6]  = mk(4096,   1, 0, 0,  1, 'h2800, 0, 0, 0);
        tbl[7]  = mk(4096,   1, 0, 0,  1, 'h2C00, 0, 0, 0);
        tbl[8]  = mk(20000,  1, 0, 0,  1, 'h3000, 0, 1, 1);
        tbl[9]  = mk(-20000, 1, 0, 0,  1, 'h3FFF, 0, 1, 2);
        tbl[10] = mk(4096,   1, 0, 0,  1, 'h0000, 0, 1, 2);
        tbl[11] = mk(-8192,  1, 0, 0,  1, 'h3000, 0, 1, 2);
        tbl[12] = mk(8191,   1, 0, 0,  1, 'h0000, 0, 1, 2);
        tbl[13] = mk(8192,   1, 0, 0,  1, 'h3FFF, 0, 1, 3);
        tbl[14] = mk(-8193,  1, 0, 0,  1, 'h3FFF, 0, 1, 4);
        tbl[15] = mk(0,      0, 0, 1,  1, 'h0000, 0, 0, 0);
        tbl[16] = mk(0,      0, 0, 0,  0, 'h0000, 0, 0, 0);
        tbl[17] = mk(-1,     1, 0, 0,  0, 'h0000, 0, 0, 0);
        tbl[18] = mk(0,      0, 1, 0,  1, 'h1FFF, 1, 0, 0);
        tbl[19] = mk(291,    1, 1, 0,  0, 'h1FFF, 1, 0, 0);
        tbl[20] = mk(291,    1, 1, 0,  1, 'h2123, 1, 0, 0);
        tbl[21] = mk(-291,   1, 1, 0,  1, 'h20DA, 1, 0, 0);
        tbl[22] = mk(-291,   1, 1, 0,  1, 'h1F6E, 0, 0, 0);
        tbl[23] = mk(0,      0, 1, 0,  1, 'h1FB7, 0, 0, 0);
        tbl[24] = mk(0,      0, 1, 0,  0, 'h1FB7, 0, 0, 0);
        tbl[25] = mk(0,      0, 0, 0,  0, 'h1FB7, 1, 0, 0);
        tbl[26] = mk(4096,   1, 0, 0,  0, 'h1FB7, 1, 0, 0);
        tbl[27] = mk(4096,   1, 0, 0,  1, 'h2000, 1, 0, 0);
        tbl[28] = mk(0,      0, 1, 0,  1, 'h2400, 1, 0, 0);
        tbl[29] = mk(4096,   1, 1, 0,  0, 'h2400, 1, 0, 0);
        tbl[30] = mk(4096,   1, 1, 0,  1, 'h2800, 0, 0, 0);
        tbl[31] = mk(4096,   1, 1, 0,  1, 'h2400, 0, 0, 0);
        tbl[32] = mk(0,      0, 1, 0,  1, 'h2000, 0, 0, 0);
        tbl[33] = mk(0,      0, 1, 0,  0, 'h2000, 0, 0, 0);

        rst       = 1'b1;
        din       = 16'h0000;
        din_valid = 1'b0;
        mute      = 1'b1;
        clip_clr  = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        chk_all("reset", 1'b0, 14'h2000, 1'b0, 1'b0, 16'h0000);
        rst = 1'b0;

        for (int i = 0; i < 34; i++) begin
            step(int'($signed(tbl[i].din)), tbl[i].vld, tbl[i].mute, tbl[i].clr);
            chk_all($sformatf("v%0d", i), tbl[i].ev, tbl[i].eo, tbl[i].eb, tbl[i].ef, tbl[i].ec);
        end

        // Clip counter saturation and clear priority.
        for (int i = 0; i < 65535; i++) step(20000, 1'b1, 1'b1, 1'b0);
        n_vec++;
        chk("clip_cnt_65535", 32'(clip_count), 32'h0000FFFF);
        step(20000, 1'b1, 1'b1, 1'b0);
        step(-20000, 1'b1, 1'b1, 1'b0);
        n_vec++;
        chk("clip_cnt_sat", 32'(clip_count), 32'h0000FFFF);
        chk("clip_flag_sat", 32'(clip_flag), 32'h1);
        step(20000, 1'b1, 1'b1, 1'b1);
        n_vec++;
        chk("clr_win_cnt", 32'(clip_count), 32'h0);
        chk("clr_win_flag", 32'(clip_flag), 32'h0);
        step(-20000, 1'b1, 1'b1, 1'b0);
        step(100, 1'b1, 1'b1, 1'b0);
        n_vec++;
        chk("clip_after_clr_cnt", 32'(clip_count), 32'h1);
        chk("clip_after_clr_flag", 32'(clip_flag), 32'h1);

        // Reach RUN, then reset while a sample is in flight.
        step(0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) step(4096, 1'b1, 1'b0, 1'b0);
        step(0, 1'b0, 1'b0, 1'b0);
        step(0, 1'b0, 1'b0, 1'b0);
        n_vec++;
        chk("pre_rst_out", 32'(dac_out), 32'h2C00);
        chk("pre_rst_busy", 32'(ramp_busy), 32'h0);
        step(4096, 1'b1, 1'b0, 1'b0);
        din_valid = 1'b0;
        mute      = 1'b1;
        #2;
        rst = 1'b1;
        #1;
        chk_all("rst_async", 1'b0, 14'h2000, 1'b0, 1'b0, 16'h0000);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst  = 1'b0;
        seen = 0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
            if (dac_valid) seen++;
        end
        n_vec++;
        chk("rst_no_valid", 32'(seen), 32'h0);
        chk_all("post_rst", 1'b0, 14'h2000, 1'b0, 1'b0, 16'h0000);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
